// File: rtl/uart_pkt_tx.sv
// Byte FIFO drained on command into framed UART packets: SOF, LEN, payload, CSUM.
// CSUM is the 8-bit modular sum of the payload bytes only.
module uart_pkt_tx #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  SOF_BYTE     = 8'h7E
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [7:0]                        data_in,
  input  logic                              send,
  output logic                              tx_out,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              tx_busy,
  output logic                              pkt_done,
  output logic                              overflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned NBITS = 10 + ((PARITY != 0) ? 1 : 0) + (STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StSof, StLen, StPayload, StCsum, StDone} state_e;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop;
  logic [7:0]    rd_data;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign push       = wr_en && !fifo_full;
  assign rd_data    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_q + CW'(push) - CW'(pop);
      // Full rejects the write even if a pop frees a slot this cycle.
      overflow_q <= wr_en && fifo_full;
    end
  end

  // ---------------- Serializer ----------------
  logic          load;
  logic [7:0]    load_byte;
  logic [11:0]   frame;
  logic [11:0]   sh_q;
  logic [3:0]    left_q;
  logic [BW-1:0] baud_q;
  logic          active_q, tx_q;
  logic          baud_last, ser_ready;

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Ready on the last cycle of the final stop bit so frames run back-to-back.
  assign ser_ready = !active_q || (baud_last && (left_q == 4'd0));
  assign tx_out    = tx_q;

  always_comb begin
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = load_byte;
    if (PARITY != 0) frame[9] = (PARITY == 1) ? ^load_byte : ~^load_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      left_q   <= '0;
      baud_q   <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load) begin
      tx_q     <= 1'b0;
      sh_q     <= frame >> 1;
      left_q   <= 4'(NBITS - 1);
      baud_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (baud_last) begin
        baud_q <= '0;
        if (left_q == 4'd0) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          tx_q   <= sh_q[0];
          sh_q   <= sh_q >> 1;
          left_q <= left_q - 4'd1;
        end
      end else begin
        baud_q <= baud_q + BW'(1);
      end
    end
  end

  // ---------------- Framing FSM ----------------
  state_e        state_q, state_d;
  logic [CW-1:0] len_q, rem_q;
  logic [7:0]    csum_q;
  logic          done_q;
  logic          accept, finish;

  assign tx_busy  = (state_q != StIdle);
  assign pkt_done = done_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_byte = SOF_BYTE;
    pop       = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (send && !fifo_empty) begin
          accept  = 1'b1;
          state_d = StSof;
        end
      end
      StSof: begin
        if (ser_ready) begin
          load    = 1'b1;
          state_d = StLen;
        end
      end
      StLen: begin
        load_byte = 8'(len_q);
        if (ser_ready) begin
          load    = 1'b1;
          state_d = StPayload;
        end
      end
      StPayload: begin
        load_byte = rd_data;
        if (ser_ready) begin
          load = 1'b1;
          pop  = 1'b1;
          if (rem_q == CW'(1)) state_d = StCsum;
        end
      end
      StCsum: begin
        load_byte = csum_q;
        if (ser_ready) begin
          load    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ser_ready) begin
          finish  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (accept) begin
        len_q  <= count_q;
        rem_q  <= count_q;
        csum_q <= '0;
      end
      if (pop) begin
        rem_q  <= rem_q - CW'(1);
        csum_q <= csum_q + rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx: samples the TX line every cycle and decodes frames
// from the recorded samples at fixed bit offsets.
module tb_uart_pkt_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data = 8'h00;
  logic wr_a = 0, send_a = 0, wr_e = 0, send_e = 0, wr_o = 0, send_o = 0;
  logic tx_a, full_a, empty_a, busy_a, done_a, ovf_a;
  logic tx_e, full_e, empty_e, busy_e, done_e, ovf_e;
  logic tx_o, full_o, empty_o, busy_o, done_o, ovf_o;
  logic [4:0] count_a, count_e, count_o;

  uart_pkt_tx #(.FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .data_in(data), .send(send_a), .tx_out(tx_a),
    .fifo_full(full_a), .fifo_empty(empty_a), .fifo_count(count_a), .tx_busy(busy_a),
    .pkt_done(done_a), .overflow(ovf_a));

  uart_pkt_tx #(.FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .wr_en(wr_e), .data_in(data), .send(send_e), .tx_out(tx_e),
    .fifo_full(full_e), .fifo_empty(empty_e), .fifo_count(count_e), .tx_busy(busy_e),
    .pkt_done(done_e), .overflow(ovf_e));

  uart_pkt_tx #(.FIFO_DEPTH(16), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_o (
    .clk(clk), .rst(rst), .wr_en(wr_o), .data_in(data), .send(send_o), .tx_out(tx_o),
    .fifo_full(full_o), .fifo_empty(empty_o), .fifo_count(count_o), .tx_busy(busy_o),
    .pkt_done(done_o), .overflow(ovf_o));

  int n_checks = 0;
  int n_fail   = 0;
  logic samp[$];
  int done_idx;
  int pulses;

  function automatic logic line_of(input int sel);
    return (sel == 0) ? tx_a : (sel == 1) ? tx_e : tx_o;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : (sel == 1) ? done_e : done_o;
  endfunction

  // Called at a negedge; drives for one cycle.
  task automatic push(input int sel, input logic [7:0] b);
    data = b;
    if (sel == 0) wr_a = 1'b1;
    else if (sel == 1) wr_e = 1'b1;
    else wr_o = 1'b1;
    @(negedge clk);
    wr_a = 1'b0; wr_e = 1'b0; wr_o = 1'b0;
  endtask

  task automatic send(input int sel);
    if (sel == 0) send_a = 1'b1;
    else if (sel == 1) send_e = 1'b1;
    else send_o = 1'b1;
    @(negedge clk);
    send_a = 1'b0; send_e = 1'b0; send_o = 1'b0;
  endtask

  // Sample index 0 is the negedge right after the send-accept edge.
  task automatic capture(input int sel, input int budget);
    samp.delete();
    done_idx = -1;
    pulses   = 0;
    for (int i = 0; i < budget; i++) begin
      samp.push_back(line_of(sel));
      if (done_of(sel)) begin
        pulses++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx >= 0 && i >= done_idx + 3) break;
      @(negedge clk);
    end
  endtask

  function automatic int first_low();
    for (int i = 0; i < samp.size(); i++) if (samp[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic bit_at(input int s, input int b, input int k, input int j);
    int idx;
    idx = s + (k * b + j) * CPB + 1;
    if (s < 0 || idx >= samp.size()) return 1'bx;
    return samp[idx];
  endfunction

  function automatic logic [7:0] byte_at(input int s, input int b, input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = bit_at(s, b, k, 1 + i);
    return r;
  endfunction

  task automatic test_reset();
    #12 rst = 1'b1;
    #1;
    n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    n_checks++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_a); end
    n_checks++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if ({done_a, ovf_a} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {done_a, ovf_a}); end
    n_checks++; if ({tx_e, tx_o} !== 2'b11) begin n_fail++; $display("FAIL reset_tx_par: got %b want 11", {tx_e, tx_o}); end
    repeat (3) @(negedge clk);
    n_checks++; if ({tx_a, empty_a, busy_a, count_a} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL reset_hold: got tx=%b empty=%b busy=%b count=%0d", tx_a, empty_a, busy_a, count_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({tx_a, empty_a, busy_a} !== 3'b110) begin n_fail++; $display("FAIL reset_release: got %b want 110", {tx_a, empty_a, busy_a}); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [6];
    int s;
    exp = '{8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    n_checks++; if (count_a !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", count_a); end
    send(0);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    capture(0, 400);
    s = first_low();
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL basic_start: got %0d want 1", s); end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (byte_at(s, 10, k) !== exp[k]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h want %h", k, byte_at(s, 10, k), exp[k]);
      end
    end
    n_checks++; if (bit_at(s, 10, 5, 9) !== 1'b1) begin n_fail++; $display("FAIL basic_stop: got %b want 1", bit_at(s, 10, 5, 9)); end
    n_checks++; if (done_idx - s !== 240) begin n_fail++; $display("FAIL basic_len: got %0d want 240", done_idx - s); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d want 1", pulses); end
    n_checks++; if ({empty_a, busy_a, tx_a} !== 3'b101) begin n_fail++; $display("FAIL basic_end: got %b want 101", {empty_a, busy_a, tx_a}); end
  endtask

  task automatic test_full_overflow();
    int s;
    for (int i = 1; i <= 16; i++) push(0, 8'(i));
    n_checks++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full_a); end
    n_checks++; if (count_a !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", count_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", ovf_a); end
    push(0, 8'hAA);
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", ovf_a); end
    n_checks++; if (count_a !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count_a); end
    @(negedge clk);
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_width: got %b want 0", ovf_a); end
    send(0);
    capture(0, 1000);
    s = first_low();
    n_checks++; if (byte_at(s, 10, 1) !== 8'h10) begin n_fail++; $display("FAIL full_len: got %h want 10", byte_at(s, 10, 1)); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (byte_at(s, 10, 2 + i) !== 8'(i + 1)) begin
        n_fail++; $display("FAIL full_payload%0d: got %h want %h", i, byte_at(s, 10, 2 + i), 8'(i + 1));
      end
    end
    n_checks++; if (byte_at(s, 10, 18) !== 8'h88) begin n_fail++; $display("FAIL full_csum: got %h want 88", byte_at(s, 10, 18)); end
    n_checks++; if (done_idx - s !== 760) begin n_fail++; $display("FAIL full_dur: got %0d want 760", done_idx - s); end
  endtask

  task automatic test_parity();
    int s;
    push(1, 8'h07);
    send(1);
    capture(1, 400);
    s = first_low();
    n_checks++; if (byte_at(s, 12, 2) !== 8'h07) begin n_fail++; $display("FAIL even_data: got %h want 07", byte_at(s, 12, 2)); end
    n_checks++; if (bit_at(s, 12, 2, 9) !== 1'b1) begin n_fail++; $display("FAIL even_par: got %b want 1", bit_at(s, 12, 2, 9)); end
    n_checks++; if ({bit_at(s, 12, 2, 10), bit_at(s, 12, 2, 11)} !== 2'b11) begin
      n_fail++; $display("FAIL even_stops: got %b want 11", {bit_at(s, 12, 2, 10), bit_at(s, 12, 2, 11)});
    end
    n_checks++; if (bit_at(s, 12, 0, 9) !== 1'b0) begin n_fail++; $display("FAIL even_sof_par: got %b want 0", bit_at(s, 12, 0, 9)); end
    n_checks++; if (byte_at(s, 12, 3) !== 8'h07) begin n_fail++; $display("FAIL even_csum: got %h want 07", byte_at(s, 12, 3)); end
    n_checks++; if (done_idx - s !== 192) begin n_fail++; $display("FAIL even_dur: got %0d want 192", done_idx - s); end
    push(2, 8'h07);
    send(2);
    capture(2, 400);
    s = first_low();
    n_checks++; if (byte_at(s, 12, 2) !== 8'h07) begin n_fail++; $display("FAIL odd_data: got %h want 07", byte_at(s, 12, 2)); end
    n_checks++; if (bit_at(s, 12, 2, 9) !== 1'b0) begin n_fail++; $display("FAIL odd_par: got %b want 0", bit_at(s, 12, 2, 9)); end
    n_checks++; if (bit_at(s, 12, 0, 9) !== 1'b1) begin n_fail++; $display("FAIL odd_sof_par: got %b want 1", bit_at(s, 12, 0, 9)); end
    n_checks++; if (done_idx - s !== 192) begin n_fail++; $display("FAIL odd_dur: got %0d want 192", done_idx - s); end
  endtask

  task automatic test_ignored();
    logic busy_seen, low_seen;
    logic [7:0] exp [5];
    int s;
    busy_seen = 1'b0;
    low_seen  = 1'b0;
    send(0);
    for (int i = 0; i < 10; i++) begin
      busy_seen |= busy_a;
      low_seen  |= ~tx_a;
      @(negedge clk);
    end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL empty_send_busy: got %b want 0", busy_seen); end
    n_checks++; if (low_seen !== 1'b0) begin n_fail++; $display("FAIL empty_send_tx: got %b want 0", low_seen); end
    push(0, 8'h10); push(0, 8'h20);
    send(0);
    fork
      capture(0, 400);
      begin
        repeat (50) @(negedge clk);
        send(0);
        push(0, 8'h31); push(0, 8'h32); push(0, 8'h33);
      end
    join
    exp = '{8'h7E, 8'h02, 8'h10, 8'h20, 8'h30};
    s = first_low();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (byte_at(s, 10, k) !== exp[k]) begin
        n_fail++; $display("FAIL ign_byte%0d: got %h want %h", k, byte_at(s, 10, k), exp[k]);
      end
    end
    n_checks++; if (done_idx - s !== 200) begin n_fail++; $display("FAIL ign_dur: got %0d want 200", done_idx - s); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ign_pulse: got %0d want 1", pulses); end
    n_checks++; if (count_a !== 5'd3) begin n_fail++; $display("FAIL ign_count: got %0d want 3", count_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ign_busy: got %b want 0", busy_a); end
    send(0);
    capture(0, 400);
    s = first_low();
    n_checks++; if (byte_at(s, 10, 1) !== 8'h03) begin n_fail++; $display("FAIL next_len: got %h want 03", byte_at(s, 10, 1)); end
    n_checks++; if (byte_at(s, 10, 4) !== 8'h33) begin n_fail++; $display("FAIL next_last: got %h want 33", byte_at(s, 10, 4)); end
    n_checks++; if (byte_at(s, 10, 5) !== 8'h96) begin n_fail++; $display("FAIL next_csum: got %h want 96", byte_at(s, 10, 5)); end
  endtask

  task automatic test_reset_mid_payload();
    int s;
    int seen;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    send(0);
    // Lands inside data bit 0 of the second payload byte (8'h22), which is low.
    repeat (126) @(negedge clk);
    n_checks++; if (tx_a !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tx: got %b want 0", tx_a); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", tx_a); end
    n_checks++; if ({empty_a, count_a, busy_a} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_rst_state: got empty=%b count=%0d busy=%b", empty_a, count_a, busy_a);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_a || !tx_a) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", seen); end
    push(0, 8'h5A);
    send(0);
    capture(0, 400);
    s = first_low();
    n_checks++; if (byte_at(s, 10, 1) !== 8'h01) begin n_fail++; $display("FAIL fresh_len: got %h want 01", byte_at(s, 10, 1)); end
    n_checks++; if (byte_at(s, 10, 2) !== 8'h5A) begin n_fail++; $display("FAIL fresh_data: got %h want 5a", byte_at(s, 10, 2)); end
    n_checks++; if (byte_at(s, 10, 3) !== 8'h5A) begin n_fail++; $display("FAIL fresh_csum: got %h want 5a", byte_at(s, 10, 3)); end
    n_checks++; if (done_idx - s !== 160) begin n_fail++; $display("FAIL fresh_dur: got %0d want 160", done_idx - s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_parity();
    test_ignored();
    test_reset_mid_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
